// File: rtl/serial_add_if.sv
// Request/result bundle for the bit-serial adder.
// With SERIAL_ADD_OVF_EN defined the bundle also carries the signed-overflow flag ovf.
interface serial_add_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/fa.sv
// Single-bit full adder cell shared by the bit-serial datapath.
module fa (
  output logic co,
  output logic s,
  input  logic ci,
  input  logic x,
  input  logic y
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/serial_add.sv
// Bit-serial N-bit adder: one fa cell, operands consumed LSB first, N RUN cycles per add.
// Optional macro SERIAL_ADD_OVF_EN adds the signed two's-complement overflow output ovf.
module serial_add #(
  parameter int N = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  serial_add_if.slave bus
);
  localparam int            CW   = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e        state_q;
  logic [N-1:0]  a_sh_q;
  logic [N-1:0]  b_sh_q;
  logic [N-1:0]  sum_sh_q;
  logic [N-1:0]  sum_sh_d;
  logic [N-1:0]  sum_q;
  logic [CW-1:0] count_q;
  logic          carry_q;
  logic          cout_q;
  logic          busy_q;
  logic          done_q;
  logic          fa_s;
  logic          fa_co;
`ifdef SERIAL_ADD_OVF_EN
  logic          c_msb_q;
  logic          ovf_q;
`endif

  fa u_fa (
    .co (fa_co),
    .s  (fa_s),
    .ci (carry_q),
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0])
  );

  // Sum bits enter at the top and walk down, so bit 0 ends in sum_sh_q[0].
  assign sum_sh_d = {fa_s, sum_sh_q[N-1:1]};

  // NOTE: every register here is written with <= so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      count_q  <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      c_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh_q   <= bus.a;
            b_sh_q   <= bus.b;
            carry_q  <= bus.cin;
            count_q  <= '0;
            sum_sh_q <= '0;
            state_q  <= RUN;
          end
        end

        RUN: begin
          busy_q   <= 1'b1;
          done_q   <= 1'b0;
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          sum_sh_q <= sum_sh_d;
          carry_q  <= fa_co;
          count_q  <= count_q + 1'b1;
          if (count_q == LAST) begin
`ifdef SERIAL_ADD_OVF_EN
            // Carry entering the MSB position, needed for the signed overflow test.
            c_msb_q <= carry_q;
`endif
            state_q <= DONE;
          end
        end

        DONE: begin
          busy_q  <= 1'b1;
          done_q  <= 1'b1;
          sum_q   <= sum_sh_q;
          cout_q  <= carry_q;
`ifdef SERIAL_ADD_OVF_EN
          ovf_q   <= c_msb_q ^ carry_q;
`endif
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule
